// File: rtl/cla_app_pkg.sv
// Shared constants, segment-count helper and per-stage control record for the
// segmented approximate carry-look-ahead pipeline.
package cla_app_pkg;

  localparam int unsigned CLA_WIDTH_DEF    = 16;
  localparam int unsigned CLA_SEG_DEF      = 4;
  localparam int unsigned CLA_APP_SEGS_DEF = 3;

  function automatic int unsigned cla_nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  // Control part of a stage record; the width-dependent data fields are
  // appended by the top, which owns WIDTH.
  typedef struct packed {
    logic valid;
    logic carry;
    logic mode;
  } cla_ctl_t;

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit lookahead segment. Sum is always exact for the given
// carry-in; approx_i selects the truncated two-bit carry-out.
module cla_seg
  import cla_app_pkg::*;
#(
  parameter int unsigned SEG = CLA_SEG_DEF
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  input  logic           approx_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           cout_apx;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int unsigned i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_o = p ^ c[SEG-1:0];
  end

  // The approximate carry looks only at the top two bit positions.
  if (SEG >= 2) begin : g_apx2
    assign cout_apx = g[SEG-1] | (p[SEG-1] & g[SEG-2]);
  end else begin : g_apx1
    assign cout_apx = g[0];
  end

  assign cout_o = approx_i ? cout_apx : c[SEG];

endmodule

// File: rtl/cla_app_pipe.sv
// Pipelined segmented approximate CLA adder, one register stage per segment,
// valid/ready handshake. Optional error statistics: CLA_APP_ERR_STAT_EN.
module cla_app_pipe
  import cla_app_pkg::*;
#(
  parameter int unsigned WIDTH    = CLA_WIDTH_DEF,
  parameter int unsigned SEG      = CLA_SEG_DEF,
  parameter int unsigned APP_SEGS = CLA_APP_SEGS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_APP_ERR_STAT_EN
  ,
  output logic             err_flag,
  output logic [15:0]      err_cnt
`endif
);

  localparam int unsigned NSEG = cla_nseg(WIDTH, SEG);
  localparam int unsigned LAST = NSEG - 1;

  typedef struct packed {
    cla_ctl_t         ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef CLA_APP_ERR_STAT_EN
    logic             ex_carry;
    logic [WIDTH-1:0] ex_sum;
`endif
  } stage_t;

  stage_t         stage_q  [NSEG];
  stage_t         stage_d  [NSEG];
  stage_t         stage_in [NSEG];
  logic [SEG-1:0] seg_sum  [NSEG];
  logic           seg_cout [NSEG];
  logic           advance;

  assign advance   = !stage_q[LAST].ctl.valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_q[LAST].ctl.valid;
  assign sum       = stage_q[LAST].sum;
  assign cout      = stage_q[LAST].ctl.carry;

  // Stage 0 reads the ports; every later stage reads its predecessor's register.
  always_comb begin
    stage_in[0]           = '0;
    stage_in[0].ctl.valid = in_valid;
    stage_in[0].ctl.carry = cin;
    stage_in[0].ctl.mode  = approx_en;
    stage_in[0].a         = a;
    stage_in[0].b         = b;
`ifdef CLA_APP_ERR_STAT_EN
    stage_in[0].ex_carry  = cin;
`endif
    for (int unsigned k = 1; k < NSEG; k++) begin
      stage_in[k] = stage_q[k-1];
    end
  end

`ifdef CLA_APP_ERR_STAT_EN
  logic [SEG-1:0] ex_seg_sum  [NSEG];
  logic           ex_seg_cout [NSEG];
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic approx;

    if ((k < APP_SEGS) && (k != LAST)) begin : g_apx
      assign approx = stage_in[k].ctl.mode;
    end else begin : g_exact
      assign approx = 1'b0;
    end

    cla_seg #(
      .SEG (SEG)
    ) u_seg (
      .a_i      (stage_in[k].a[k*SEG +: SEG]),
      .b_i      (stage_in[k].b[k*SEG +: SEG]),
      .cin_i    (stage_in[k].ctl.carry),
      .approx_i (approx),
      .sum_o    (seg_sum[k]),
      .cout_o   (seg_cout[k])
    );

`ifdef CLA_APP_ERR_STAT_EN
    cla_seg #(
      .SEG (SEG)
    ) u_seg_ref (
      .a_i      (stage_in[k].a[k*SEG +: SEG]),
      .b_i      (stage_in[k].b[k*SEG +: SEG]),
      .cin_i    (stage_in[k].ex_carry),
      .approx_i (1'b0),
      .sum_o    (ex_seg_sum[k]),
      .cout_o   (ex_seg_cout[k])
    );
`endif
  end

  always_comb begin
    for (int unsigned k = 0; k < NSEG; k++) begin
      stage_d[k]                   = stage_in[k];
      stage_d[k].sum[k*SEG +: SEG] = seg_sum[k];
      stage_d[k].ctl.carry         = seg_cout[k];
`ifdef CLA_APP_ERR_STAT_EN
      stage_d[k].ex_sum[k*SEG +: SEG] = ex_seg_sum[k];
      stage_d[k].ex_carry             = ex_seg_cout[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

`ifdef CLA_APP_ERR_STAT_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  assign err_flag = {cout, sum} != {stage_q[LAST].ex_carry, stage_q[LAST].ex_sum};
  assign err_cnt  = err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && err_flag && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cla_app_pipe.sv
// Self-checking bench for cla_app_pipe: directed vectors, streaming, stall,
// reset flush and randomized traffic against a segment-arithmetic model.
module tb_cla_app_pipe;

  localparam int W        = 16;
  localparam int SEG      = 4;
  localparam int APP_SEGS = 3;
  localparam int NSEG     = W / SEG;
  localparam int MASK     = (1 << SEG) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_APP_ERR_STAT_EN
  logic         err_flag;
  logic [15:0]  err_cnt;
`endif

  cla_app_pipe #(
    .WIDTH    (W),
    .SEG      (SEG),
    .APP_SEGS (APP_SEGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_APP_ERR_STAT_EN
    ,
    .err_flag  (err_flag),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Segment-by-segment arithmetic: exact segment sums, carry between segments
  // either the true overflow or the overflow of the top two bit positions alone.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic ap);
    int unsigned carry, xs, ys, s;
    logic [W:0]  r;
    r     = '0;
    carry = 32'(c);
    for (int k = 0; k < NSEG; k++) begin
      xs = 32'(x >> (k * SEG)) & MASK;
      ys = 32'(y >> (k * SEG)) & MASK;
      s  = xs + ys + carry;
      r[k*SEG +: SEG] = SEG'(s & MASK);
      if (ap && k < APP_SEGS) carry = (((xs >> (SEG - 2)) + (ys >> (SEG - 2))) >= 4) ? 1 : 0;
      else                    carry = s >> SEG;
    end
    r[W] = (carry != 0);
    return r;
  endfunction

  function automatic logic [W:0] exact(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  typedef struct {
    logic [W:0] res;
    logic       flag;
    int         acc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc        = 0;
  bit          lat_chk_en = 1'b0;
  bit          rand_rdy   = 1'b0;
  bit          hold_v     = 1'b0;
  logic [W:0]  hold_val;
  logic [15:0] err_cnt_m  = '0;

  // Monitor: everything sampled at the falling edge reflects what the next
  // rising edge will do.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (hold_v && out_valid) chk("stall_hold", 32'({cout, sum}), 32'(hold_val));
`ifdef CLA_APP_ERR_STAT_EN
      chk("err_cnt", 32'(err_cnt), 32'(err_cnt_m));
`endif
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("result", 32'({cout, sum}), 32'(e.res));
          if (lat_chk_en) chk("latency", 32'(cyc - e.acc), 32'(NSEG));
`ifdef CLA_APP_ERR_STAT_EN
          chk("err_flag", 32'(err_flag), 32'(e.flag));
`endif
          if (e.flag && err_cnt_m != 16'hFFFF) err_cnt_m++;
        end
      end
      if (in_valid && in_ready) begin
        e.res  = model(a, b, cin, approx_en);
        e.flag = (e.res != exact(a, b, cin));
        e.acc  = cyc;
        sbq.push_back(e);
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {cout, sum};
    end else begin
      hold_v = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic tap);
    int n;
    n = 0;
    a = ta; b = tb_v; cin = tc; approx_en = tap; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_snap;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; approx_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
`ifdef CLA_APP_ERR_STAT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    out_ready = 1'b1;

    // Directed vectors, each sent to an empty pipe to measure latency.
    lat_chk_en = 1'b1;
    send(16'h000F, 16'h0001, 1'b0, 1'b1); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1); drain();
    send(16'h000F, 16'h0001, 1'b0, 1'b0); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    send(16'h0008, 16'h0008, 1'b0, 1'b1); drain();
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); drain();
`ifdef CLA_APP_ERR_STAT_EN
    chk("err_cnt_directed", 32'(err_cnt), 32'(2));
`endif

    // Back-to-back stream: constant latency implies consecutive in-order results.
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
    lat_chk_en = 1'b0;

    // Fill the pipe with the output blocked, then hold the stall.
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    a = 16'h1234; b = 16'h0FF8; cin = 1'b1; approx_en = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset with three items in flight; nothing of them may emerge.
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    sbq.delete();
    err_cnt_m = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_in_ready", 32'(in_ready), 32'(1));
`ifdef CLA_APP_ERR_STAT_EN
    chk("flush_err_cnt", 32'(err_cnt), 32'(0));
`endif
    idle(8);
    chk("flush_no_stale", 32'(out_valid), 32'(0));

    // Random traffic with gaps and random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra : W'($urandom);
      send(ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Exact-mode traffic must never flag an error.
    cnt_snap = err_cnt_m;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
`ifdef CLA_APP_ERR_STAT_EN
    chk("err_cnt_exact", 32'(err_cnt), 32'(cnt_snap));
`else
    chk("model_cnt_exact", 32'(err_cnt_m), 32'(cnt_snap));
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
